// File: rtl/pixel_frame_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_frame_sequencer
//
// Frame timing controller for the pixel datapath. Walks a raster of
// IMG_WIDTH x IMG_HEIGHT active pixels, inserting HBLANK_CYC idle cycles
// after every line and VBLANK_CYC idle cycles after every frame. Active
// pixels are paced by the pixel source: a pixel is only presented when the
// source was ready on the previous cycle.
//
// Ports:
//   pixclk        pixel clock
//   reset         synchronous, active-low reset
//   i_start       level; sampled in IDLE to begin a run
//   i_stop        one-cycle request; finish the current frame, then done
//   i_src_ready   pixel source has data; low stalls active pixels
//   o_valid       pixel valid
//   o_x_coord     column of the current pixel
//   o_y_coord     row of the current pixel
//   o_sof         first pixel of a frame
//   o_eol         last pixel of a line
//   o_eof         last pixel of a frame
//   o_frame_cnt   completed frames, wraps 0xFFFF -> 0, cleared only by reset
//   o_busy        sequencer is not idle
//   o_done        one-cycle pulse when a run completes
// ---------------------------------------------------------------------------
module pixel_frame_sequencer #(
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300,
  parameter int HBLANK_CYC = 16,
  parameter int VBLANK_CYC = 64,
  parameter int FRAMES     = 1,
  parameter int XW         = 12,
  parameter int YW         = 12
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_src_ready,
  output logic          o_valid,
  output logic [XW-1:0] o_x_coord,
  output logic [YW-1:0] o_y_coord,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic [15:0]   o_frame_cnt,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_HBLANK = 3'd2,
    ST_VBLANK = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // The blank counter runs 0..N-1 for the longer of the two blanking periods.
  localparam int BLANK_MAX = (HBLANK_CYC > VBLANK_CYC) ? HBLANK_CYC : VBLANK_CYC;
  localparam int BW        = (BLANK_MAX > 2) ? $clog2(BLANK_MAX) : 1;

  localparam logic [BW-1:0] HB_LAST  = BW'((HBLANK_CYC > 0) ? HBLANK_CYC - 1 : 0);
  localparam logic [BW-1:0] VB_LAST  = BW'((VBLANK_CYC > 0) ? VBLANK_CYC - 1 : 0);
  localparam logic [BW-1:0] B_ONE    = BW'(1);
  localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0] Y_ONE    = YW'(1);
  localparam logic [15:0]   FRAMES_C = 16'(FRAMES);

  state_t          r_state;
  state_t          w_next_state;
  logic            r_valid;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [15:0]     r_frame_cnt;
  logic [BW-1:0]   r_blank_cnt;
  logic            r_stop;
  logic            r_busy;
  logic            r_done;

  logic            w_sof;
  logic            w_eol;
  logic            w_eof;
  logic            w_pix_adv;
  logic [15:0]     w_frame_cnt_inc;
  logic            w_stop_seen;
  logic            w_limit_at_eof;
  logic            w_limit_in_vblank;
  logic            w_exit_at_eof;
  logic            w_exit_in_vblank;

  // Frame markers are plain decodes of the registered pixel position.
  assign w_sof = r_valid && (r_x == {XW{1'b0}}) && (r_y == {YW{1'b0}});
  assign w_eol = r_valid && (r_x == X_LAST);
  assign w_eof = w_eol && (r_y == Y_LAST);

  // A pixel is consumed only on a valid cycle; stalls freeze x and y.
  assign w_pix_adv = (r_state == ST_ACTIVE) && r_valid;

  assign w_frame_cnt_inc = r_frame_cnt + 16'd1;

  // A stop arriving in the same cycle as the decision point still counts.
  assign w_stop_seen = r_stop || i_stop;

  // At eof the counter has not yet been updated, so compare its next value;
  // in VBLANK it already holds the completed-frame count.
  assign w_limit_at_eof    = (FRAMES != 0) && (w_frame_cnt_inc == FRAMES_C);
  assign w_limit_in_vblank = (FRAMES != 0) && (r_frame_cnt == FRAMES_C);
  assign w_exit_at_eof     = w_stop_seen || w_limit_at_eof;
  assign w_exit_in_vblank  = w_stop_seen || w_limit_in_vblank;

  // Next-state decode for the sequencing FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_ACTIVE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (w_eof) begin
          if (VBLANK_CYC > 0) begin
            w_next_state = ST_VBLANK;
          end else if (w_exit_at_eof) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_ACTIVE;
          end
        end else if (w_eol) begin
          if (HBLANK_CYC > 0) begin
            w_next_state = ST_HBLANK;
          end else begin
            w_next_state = ST_ACTIVE;
          end
        end else begin
          w_next_state = ST_ACTIVE;
        end
      end
      ST_HBLANK: begin
        if (r_blank_cnt == HB_LAST) begin
          w_next_state = ST_ACTIVE;
        end else begin
          w_next_state = ST_HBLANK;
        end
      end
      ST_VBLANK: begin
        if (r_blank_cnt == VB_LAST) begin
          if (w_exit_in_vblank) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_ACTIVE;
          end
        end else begin
          w_next_state = ST_VBLANK;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus the flags derived from the state being entered.
  // valid is set from src_ready on any edge that lands in ACTIVE, so the
  // first pixel after a blank or a start can appear without a dead cycle.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= (w_next_state == ST_ACTIVE) && i_src_ready;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= (w_next_state == ST_DONE);
    end
  end

  // Raster position: advance on each consumed pixel, wrap at line/frame end.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      r_x <= {XW{1'b0}};
      r_y <= {YW{1'b0}};
    end else if (r_state == ST_IDLE) begin
      r_x <= {XW{1'b0}};
      r_y <= {YW{1'b0}};
    end else if (w_pix_adv) begin
      if (w_eof) begin
        r_x <= {XW{1'b0}};
        r_y <= {YW{1'b0}};
      end else if (w_eol) begin
        r_x <= {XW{1'b0}};
        r_y <= r_y + Y_ONE;
      end else begin
        r_x <= r_x + X_ONE;
        r_y <= r_y;
      end
    end else begin
      r_x <= r_x;
      r_y <= r_y;
    end
  end

  // Completed-frame counter; free-running 16-bit wrap, survives run ends.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      r_frame_cnt <= 16'd0;
    end else if (w_pix_adv && w_eof) begin
      r_frame_cnt <= w_frame_cnt_inc;
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  // Blanking interval counter; restarts whenever a blank state is left.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      r_blank_cnt <= {BW{1'b0}};
    end else if (((r_state == ST_HBLANK) || (r_state == ST_VBLANK)) &&
                 (w_next_state == r_state)) begin
      r_blank_cnt <= r_blank_cnt + B_ONE;
    end else begin
      r_blank_cnt <= {BW{1'b0}};
    end
  end

  // Stop latch: armed by a stop while running, consumed by DONE.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      r_stop <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_stop <= 1'b0;
    end else if (i_stop && (r_state != ST_IDLE)) begin
      r_stop <= 1'b1;
    end else begin
      r_stop <= r_stop;
    end
  end

  assign o_valid     = r_valid;
  assign o_x_coord   = r_x;
  assign o_y_coord   = r_y;
  assign o_sof       = w_sof;
  assign o_eol       = w_eol;
  assign o_eof       = w_eof;
  assign o_frame_cnt = r_frame_cnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer: two instances with different timing
// configurations share one clock; expected pixels are queued per instance
// and compared as the instances present them.
module tb_pixel_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int HB_A  = 2;
  localparam int VB_A  = 3;
  localparam int FR_A  = 1;
  localparam int HB_B  = 0;
  localparam int VB_B  = 0;
  localparam int FR_B  = 2;
  localparam int MAXC  = 20000;
  localparam int TMO   = 2000;

  typedef struct {
    int x;
    int y;
    bit sof;
    bit eol;
    bit eof;
    int cnt;
    int blank;
    bit last;
    int cnt_after;
  } pix_t;

  logic pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  logic [1:0] rst_v   = 2'b00;
  logic [1:0] start_v = 2'b00;
  logic [1:0] stop_v  = 2'b00;
  logic [1:0] sr_v    = 2'b11;

  wire [1:0]  valid_v, sof_v, eol_v, eof_v, busy_v, done_v;
  wire [11:0] x_v   [2];
  wire [11:0] y_v   [2];
  wire [15:0] cnt_v [2];

  pixel_frame_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .HBLANK_CYC(HB_A), .VBLANK_CYC(VB_A),
    .FRAMES(FR_A), .XW(12), .YW(12)
  ) u_dut_a (
    .pixclk(pixclk), .reset(rst_v[0]), .i_start(start_v[0]), .i_stop(stop_v[0]),
    .i_src_ready(sr_v[0]), .o_valid(valid_v[0]), .o_x_coord(x_v[0]),
    .o_y_coord(y_v[0]), .o_sof(sof_v[0]), .o_eol(eol_v[0]), .o_eof(eof_v[0]),
    .o_frame_cnt(cnt_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0])
  );

  pixel_frame_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .HBLANK_CYC(HB_B), .VBLANK_CYC(VB_B),
    .FRAMES(FR_B), .XW(12), .YW(12)
  ) u_dut_b (
    .pixclk(pixclk), .reset(rst_v[1]), .i_start(start_v[1]), .i_stop(stop_v[1]),
    .i_src_ready(sr_v[1]), .o_valid(valid_v[1]), .o_x_coord(x_v[1]),
    .o_y_coord(y_v[1]), .o_sof(sof_v[1]), .o_eol(eol_v[1]), .o_eof(eof_v[1]),
    .o_frame_cnt(cnt_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1])
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  pix_t q_a[$];
  pix_t q_b[$];
  bit   sr_hist [0:1][0:MAXC-1];
  int   hb_p [2] = '{HB_A, HB_B};
  int   vb_p [2] = '{VB_A, VB_B};
  int   last_pix [2]  = '{0, 0};
  int   done_due [2]  = '{-1, -1};
  int   cnt_after [2] = '{0, 0};
  int   busy_chk [2]  = '{-1, -1};
  int   done_cnt [2]  = '{0, 0};
  int   stall_cnt [2] = '{0, 0};
  bit   rand_sr [2]   = '{1'b0, 1'b0};

  // Raster-order expectation for a run of nframes starting at count start_cnt.
  task automatic push_run(input int d, input int start_cnt, input int nframes, input bit ends);
    pix_t e;
    int   prev_blank;
    prev_blank = -1;
    for (int f = 0; f < nframes; f++) begin
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) begin
          e.x         = x;
          e.y         = y;
          e.sof       = (x == 0) && (y == 0);
          e.eol       = (x == W - 1);
          e.eof       = e.eol && (y == H - 1);
          e.cnt       = (start_cnt + f) % 65536;
          e.blank     = prev_blank;
          e.last      = ends && (f == nframes - 1) && e.eof;
          e.cnt_after = (start_cnt + nframes) % 65536;
          if (d == 0) q_a.push_back(e);
          else        q_b.push_back(e);
          prev_blank = e.eof ? vb_p[d] : (e.eol ? hb_p[d] : 0);
        end
      end
    end
  endtask

  // Number of frames a run lasts: until the count equals the limit, or the
  // frame in which a stop is requested, whichever comes first.
  function automatic int run_len(input int start_cnt, input int fr, input int stop_frame);
    for (int f = 1; f < 70000; f++) begin
      if (stop_frame != 0 && f == stop_frame) return f;
      if (fr != 0 && ((start_cnt + f) % 65536) == fr) return f;
    end
    return 0;
  endfunction

  // src_ready driver: stall requests win, then random or constant high.
  initial begin
    forever begin
      @(posedge pixclk);
      #2;
      for (int d = 0; d < 2; d++) begin
        if (stall_cnt[d] > 0) begin
          sr_v[d] = 1'b0;
          stall_cnt[d] = stall_cnt[d] - 1;
        end else if (rand_sr[d]) begin
          sr_v[d] = ($urandom_range(0, 3) != 0);
        end else begin
          sr_v[d] = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the expected pixel whenever an instance presents one.
  initial begin
    pix_t e;
    bit   have;
    int   n;
    forever begin
      @(negedge pixclk);
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (cyc < MAXC) sr_hist[d][cyc] = sr_v[d];
        if (valid_v[d]) begin
          have = 1'b0;
          if (d == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
          if (d == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
          tests++;
          if (!have) begin
            fails++;
            $display("FAIL dut%0d unexpected_pixel: got x=%0d y=%0d, want no pixel", d, x_v[d], y_v[d]);
          end else begin
            if (int'(x_v[d]) != e.x || int'(y_v[d]) != e.y || sof_v[d] != e.sof ||
                eol_v[d] != e.eol || eof_v[d] != e.eof || int'(cnt_v[d]) != e.cnt) begin
              fails++;
              $display("FAIL dut%0d pixel: got x=%0d y=%0d sof=%0b eol=%0b eof=%0b cnt=%0d, want x=%0d y=%0d sof=%0b eol=%0b eof=%0b cnt=%0d",
                       d, x_v[d], y_v[d], sof_v[d], eol_v[d], eof_v[d], cnt_v[d],
                       e.x, e.y, e.sof, e.eol, e.eof, e.cnt);
            end
            if (e.blank >= 0) begin
              n = last_pix[d] + e.blank;
              while (n < cyc && !sr_hist[d][n]) n++;
              tests++;
              if (n + 1 != cyc) begin
                fails++;
                $display("FAIL dut%0d pixel_timing x=%0d y=%0d: got cycle %0d, want cycle %0d", d, e.x, e.y, cyc, n + 1);
              end
            end
            last_pix[d] = cyc;
            if (e.last) begin
              done_due[d]  = cyc + vb_p[d] + 1;
              cnt_after[d] = e.cnt_after;
            end
          end
        end else begin
          tests++;
          if (sof_v[d] || eol_v[d] || eof_v[d]) begin
            fails++;
            $display("FAIL dut%0d marker_without_valid: got sof=%0b eol=%0b eof=%0b, want 000", d, sof_v[d], eol_v[d], eof_v[d]);
          end
        end
        if (done_v[d]) begin
          done_cnt[d]++;
          tests++;
          if (done_due[d] != cyc) begin
            fails++;
            $display("FAIL dut%0d done_timing: got cycle %0d, want cycle %0d", d, cyc, done_due[d]);
          end
          tests++;
          if (int'(cnt_v[d]) != cnt_after[d] || !busy_v[d] ||
              (d == 0 ? q_a.size() : q_b.size()) != 0) begin
            fails++;
            $display("FAIL dut%0d done_state: got cnt=%0d busy=%0b left=%0d, want cnt=%0d busy=1 left=0",
                     d, cnt_v[d], busy_v[d], (d == 0 ? q_a.size() : q_b.size()), cnt_after[d]);
          end
          done_due[d] = -1;
          busy_chk[d] = cyc + 1;
        end else if (done_due[d] >= 0 && cyc > done_due[d]) begin
          tests++;
          fails++;
          $display("FAIL dut%0d done_missing: got none by cycle %0d, want cycle %0d", d, cyc, done_due[d]);
          done_due[d] = -1;
        end
        if (busy_chk[d] == cyc) begin
          tests++;
          if (busy_v[d] || done_v[d]) begin
            fails++;
            $display("FAIL dut%0d after_done: got busy=%0b done=%0b, want 0 0", d, busy_v[d], done_v[d]);
          end
          busy_chk[d] = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
  endtask

  task automatic pulse_stop(input int d);
    stop_v[d] = 1'b1;
    tick();
    stop_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int base);
    int i;
    i = 0;
    while (done_cnt[d] == base && i < TMO) begin
      tick();
      i++;
    end
    tests++;
    if (done_cnt[d] == base) begin
      fails++;
      $display("FAIL dut%0d wait_done: got no done in %0d cycles, want a done pulse", d, TMO);
    end
  endtask

  task automatic wait_pix(input int d, input int x, input int y, input int cnt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (valid_v[d] && int'(x_v[d]) == x && int'(y_v[d]) == y && int'(cnt_v[d]) == cnt) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL dut%0d wait_pixel: got no pixel, want x=%0d y=%0d cnt=%0d", d, x, y, cnt);
    end
  endtask

  task automatic check_idle_zero(input int d, input string name);
    tests++;
    if (valid_v[d] || x_v[d] != 12'd0 || y_v[d] != 12'd0 || cnt_v[d] != 16'd0 || busy_v[d] || done_v[d]) begin
      fails++;
      $display("FAIL dut%0d %s: got valid=%0b x=%0d y=%0d cnt=%0d busy=%0b done=%0b, want all 0",
               d, name, valid_v[d], x_v[d], y_v[d], cnt_v[d], busy_v[d], done_v[d]);
    end
  endtask

  task automatic check_stall(input string name);
    tests++;
    if (valid_v[0] || x_v[0] != 12'd2 || y_v[0] != 12'd1 || sof_v[0] || eol_v[0] || eof_v[0]) begin
      fails++;
      $display("FAIL dut0 %s: got valid=%0b x=%0d y=%0d markers=%0b%0b%0b, want valid=0 x=2 y=1 markers=000",
               name, valid_v[0], x_v[0], y_v[0], sof_v[0], eol_v[0], eof_v[0]);
    end
  endtask

  initial begin
    bit ok;
    int nf;
    repeat (3) tick();
    check_idle_zero(0, "reset_state");
    check_idle_zero(1, "reset_state");
    rst_v = 2'b11;
    tick();

    // Single frame, source always ready.
    push_run(0, 0, run_len(0, FR_A, 0), 1'b1);
    pulse_start(0);
    wait_done(0, done_cnt[0]);
    repeat (3) tick();

    // Mid-frame reset at (2,1) of a run that would otherwise continue.
    push_run(0, 1, 1, 1'b0);
    pulse_start(0);
    wait_pix(0, 2, 1, 1, ok);
    rst_v[0] = 1'b0;
    tick();
    q_a.delete();
    done_due[0] = -1;
    rst_v[0] = 1'b1;
    check_idle_zero(0, "mid_frame_reset");
    tick();

    // Fresh run after reset with a three-cycle source stall at (2,1).
    push_run(0, 0, run_len(0, FR_A, 0), 1'b1);
    pulse_start(0);
    wait_pix(0, 1, 1, 0, ok);
    stall_cnt[0] = 3;
    tick();
    check_stall("stall_1");
    tick();
    check_stall("stall_2");
    wait_done(0, done_cnt[0]);
    repeat (2) tick();

    // Count is past the limit now: run continues until a stop in frame 2.
    rand_sr[0] = 1'b1;
    nf = run_len(1, FR_A, 2);
    push_run(0, 1, nf, 1'b1);
    pulse_start(0);
    wait_pix(0, 1, 1, 2, ok);
    pulse_stop(0);
    wait_done(0, done_cnt[0]);
    repeat (2) tick();

    // Stop while idle must be ignored.
    pulse_stop(0);
    repeat (8) tick();
    tests++;
    if (busy_v[0] || int'(cnt_v[0]) != 1 + nf) begin
      fails++;
      $display("FAIL dut0 idle_stop: got busy=%0b cnt=%0d, want busy=0 cnt=%0d", busy_v[0], cnt_v[0], 1 + nf);
    end
    push_run(0, 1 + nf, run_len(1 + nf, FR_A, 2), 1'b1);
    pulse_start(0);
    wait_pix(0, 1, 1, 2 + nf, ok);
    pulse_stop(0);
    wait_done(0, done_cnt[0]);
    rand_sr[0] = 1'b0;

    // No blanking, two frames back to back.
    push_run(1, 0, run_len(0, FR_B, 0), 1'b1);
    pulse_start(1);
    wait_done(1, done_cnt[1]);
    repeat (3) tick();

    // Counter wrap: preload near 0xFFFF, then run until the count hits the limit again.
    force u_dut_b.r_frame_cnt = 16'hFFFE;
    tick();
    release u_dut_b.r_frame_cnt;
    tick();
    tests++;
    if (cnt_v[1] != 16'hFFFE) begin
      fails++;
      $display("FAIL dut1 preload: got cnt=%0d, want %0d", cnt_v[1], 65534);
    end
    rand_sr[1] = 1'b1;
    push_run(1, 65534, run_len(65534, FR_B, 0), 1'b1);
    pulse_start(1);
    wait_done(1, done_cnt[1]);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pixel_frame_sequencer.md
Name: pixel_frame_sequencer

Overview:
Frame timing controller that drives the pixel datapath on pixclk. It produces pixel-valid, x/y coordinates and frame markers for a configurable resolution, with horizontal and vertical blanking and start/stop control. It sits between the test or pixel source and the RGB datapath. Its output stream matches what the downstream coordinate and pixel checkers expect.

Parameters:
IMG_WIDTH, 400, active pixels per line (>=2)
IMG_HEIGHT, 300, active lines per frame (>=2)
HBLANK_CYC, 16, idle cycles after each line (0 allowed)
VBLANK_CYC, 64, idle cycles after each frame (0 allowed)
FRAMES, 1, frames to emit before done; 0 = continuous
XW, 12, x_coord width (2^XW >= IMG_WIDTH)
YW, 12, y_coord width (2^YW >= IMG_HEIGHT)

Ports:
pixclk  in  1  pixel clock
reset  in  1  reset, synchronous, active-low
start  in  1  level; sampled in IDLE to begin a run
stop  in  1  one-cycle request; finish current frame, then done
src_ready  in  1  pixel source has data; low stalls active pixels
valid  out  1  pixel valid (consumer samples iRed/iGreen/iBlue)
x_coord  out  XW  column of current pixel
y_coord  out  YW  row of current pixel
sof  out  1  valid && x==0 && y==0
eol  out  1  valid && x==IMG_WIDTH-1
eof  out  1  eol && y==IMG_HEIGHT-1
frame_cnt  out  16  completed frames, wraps at 0xFFFF->0
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on run completion

Behaviour:
- Reset (reset==0 at a pixclk edge), takes effect the same edge, from any state, including mid-frame: state=IDLE; valid, x_coord, y_coord, frame_cnt, done, the blank counter and the stop latch all 0.
- All state, counters and valid are registered. sof, eol and eof are combinational decodes of the registered valid, x and y.
- States: IDLE, ACTIVE, HBLANK, VBLANK, DONE.
- IDLE, start==1: go to ACTIVE. First valid is possible on the next cycle.
- ACTIVE:
  - valid = src_ready, registered: valid in cycle n+1 reflects src_ready in cycle n while ACTIVE.
  - x advances only on a valid cycle. While valid==0 (stall), x and y hold and no marker asserts.
- End of line (valid && x==IMG_WIDTH-1, y<IMG_HEIGHT-1):
  - x<=0, y<=y+1.
  - Go to HBLANK if HBLANK_CYC>0, else stay in ACTIVE (back-to-back lines).
- End of frame (eof):
  - x<=0, y<=0, frame_cnt<=frame_cnt+1.
  - Go to VBLANK if VBLANK_CYC>0, else evaluate the exit condition immediately.
- HBLANK: exactly HBLANK_CYC cycles with valid==0, then ACTIVE.
- VBLANK: exactly VBLANK_CYC cycles with valid==0, then:
  - DONE if the stop latch is set, or if FRAMES!=0 && frame_cnt==FRAMES;
  - else ACTIVE.
- stop pulse in any non-IDLE state sets the stop latch. The current frame always completes; no truncated frame is ever emitted. stop in IDLE is ignored.
- DONE: done=1 for exactly one cycle, clear the stop latch, go to IDLE. frame_cnt holds until reset.
- The next start from IDLE resumes at x=0,y=0. frame_cnt keeps accumulating.
- src_ready low during HBLANK or VBLANK has no effect; blank counts are fixed.
- The valid-cycle count per frame is exactly IMG_WIDTH*IMG_HEIGHT.
- x never exceeds IMG_WIDTH-1 and y never exceeds IMG_HEIGHT-1.

Test Plan:
1. IMG 4x3, HBLANK 2, VBLANK 3, FRAMES 1, src_ready=1, start pulse:
   - 12 valid cycles in pattern 4 valid / 2 idle;
   - sof once at (0,0); eol at x=3 for y=0,1,2; eof at (3,2);
   - done pulses 4 cycles after eof (3 VBLANK + DONE);
   - frame_cnt=1, busy low afterwards.
2. Same config, src_ready low for 3 cycles at x=2 y=1:
   - valid low 3 cycles, x stays 2, no marker;
   - stream resumes at (2,1);
   - still exactly 12 valid cycles, coordinates monotonic.
3. FRAMES=0, stop pulse at (1,1) of frame 2:
   - frame 2 completes to eof at (3,2), then VBLANK, then done;
   - frame_cnt=2; a stop pulse while in IDLE causes nothing.
4. Reset low for 1 cycle at (2,1) mid-frame:
   - next cycle valid=0, x=y=0, frame_cnt=0, busy=0;
   - a new start produces sof at (0,0).
5. HBLANK 0, VBLANK 0, FRAMES 2:
   - 24 consecutive valid cycles, no gap between lines or frames;
   - sof twice, eof twice, frame_cnt=2, done once.
6. FRAMES=0, frame_cnt preloaded near 0xFFFF via long run (or force): wraps to 0 on the next eof, with no effect on sequencing.
